dm_bridge: RTL and testbench

DM_BRIDGE -- requirements
Module: dm_bridge

---
 rtl/dm_bridge_if.sv | 12 +
 rtl/dm_bridge.sv | 83 ++++++++
 tb/tb_dm_bridge.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dm_bridge_if.sv
// dm_bridge_if: memory-side request/ack bus between dm_bridge (master) and its slave
interface dm_bridge_if;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_wr, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_wr, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);
endinterface

// File: rtl/dm_bridge.sv
// dm_bridge: stalls the M stage while one data access runs on the memory bus;
// defining DM_BRIDGE_TIMEOUT_EN adds an abort after TIMEOUT_CYC unacked REQ cycles.
module dm_bridge #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_err,
    output logic [31:0] txn_cnt,
    dm_bridge_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        ack, tmo, done_go;
    assign ack     = state == REQ && mem.mem_ack;
    assign done_go = state == REQ && (ack || tmo);
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state == IDLE ? (cpu_req ? REQ : IDLE) :
                   state == REQ  ? (done_go ? DONE : REQ) : IDLE;
    end
    always_comb begin
        cpu_stall     = !reset && ((state == IDLE && cpu_req) || state == REQ);
        mem.mem_req   = state == REQ;
        mem.mem_wr    = state == REQ && wr_q;
        mem.mem_addr  = state == REQ ? addr_q : '0;
        mem.mem_wdata = state == REQ ? wdata_q : '0;
        mem.mem_be    = state == REQ ? be_q : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cpu_rdata <= '0;
            txn_cnt   <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                wr_q    <= cpu_wr;
                addr_q  <= {cpu_addr[31:2], 2'b00};
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
            end
            if (done_go)
                cpu_rdata <= ack && !wr_q ? mem.mem_rdata : '0;
            if (done_go && ~&txn_cnt)
                txn_cnt <= txn_cnt + 32'd1;
        end
    end
`ifdef DM_BRIDGE_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q;
    // an ack in the timeout cycle wins, so the abort needs !ack
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            tcnt  <= state == IDLE ? 8'd0 : (state == REQ && !ack) ? tcnt + 8'd1 : tcnt;
            err_q <= tmo && !ack;
        end
    end
    assign tmo     = state == REQ && tcnt == 8'(TIMEOUT_CYC - 1);
    assign bus_err = err_q;
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif
    always_ff @(posedge clk)
        assert (TIMEOUT_CYC >= 1 && TIMEOUT_CYC <= 255);
endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: randomized transactions against a transaction-level model;
// a scoreboard queue feeds a negedge monitor that checks bus, DONE results and hold behaviour.
module tb_dm_bridge;
    localparam int TO = 4;
`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cnt;
        int          stall;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata, txn_cnt;
    logic        cpu_stall, bus_err;
    dm_bridge_if bus();

    dm_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .bus_err(bus_err),
        .txn_cnt(txn_cnt), .mem(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    exp_t        q[$];
    bit          mon_en = 1'b0, prev_req = 1'b0;
    logic [31:0] hold_rdata = '0, hold_cnt = '0, model_cnt = '0;
    int          run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (bus.mem_req) begin
                if (q.size() == 0) chk("mem_req_without_txn", bus.mem_req, 1'b0);
                else begin
                    chk("mem_addr", bus.mem_addr, q[0].addr);
                    chk("mem_wdata", bus.mem_wdata, q[0].wdata);
                    chk("mem_be", bus.mem_be, q[0].be);
                    chk("mem_wr", bus.mem_wr, q[0].wr);
                end
            end else chk("mem_be_outside_req", bus.mem_be, 4'b0);
            if (cpu_stall) run++;
            if (prev_req && !bus.mem_req && q.size() > 0) begin
                e = q.pop_front();
                chk("done_rdata", cpu_rdata, e.rdata);
                chk("done_bus_err", bus_err, e.err);
                chk("done_txn_cnt", txn_cnt, e.cnt);
                chk("done_stall", cpu_stall, 1'b0);
                chk("stall_cycles", run, e.stall);
                hold_rdata = e.rdata;
                hold_cnt   = e.cnt;
                run = 0;
            end else begin
                chk("rdata_hold", cpu_rdata, hold_rdata);
                chk("txn_cnt_hold", txn_cnt, hold_cnt);
                chk("bus_err_quiet", bus_err, 1'b0);
                if (q.size() == 0) chk("stall_idle", cpu_stall, 1'b0);
            end
            prev_req = bus.mem_req;
        end
    end

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] rdata, input int d, input bit hold);
        exp_t e;
        bit   t;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        t = TMO_EN && d >= TO;
        model_cnt++;
        e = '{wr: wr, addr: {addr[31:2], 2'b00}, wdata: wdata, be: be,
              rdata: (t || wr) ? 32'h0 : rdata, err: t, cnt: model_cnt,
              stall: 1 + (t ? TO : d + 1)};
        q.push_back(e);
        for (int i = 0; i <= 64; i++) begin
            @(negedge clk);
            bus.mem_ack   = (i == d);
            bus.mem_rdata = (i == d) ? rdata : $urandom;
            #1;
            if (!bus.mem_req) break;
            if (i == 64) begin
                checks++; errors++;
                $display("FAIL done_wait actual=no_DONE required=DONE_within_64_cycles");
            end
        end
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cpu_req = 1'b0;
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_rdata = 32'hFFFF_FFFF;
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        txn(1'b0, 32'h0000_3006, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 1'b0);
        idle(2);
        txn(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, $urandom, 2, 1'b0);
        idle(1);
        txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'hA5A5_0001, 1, 1'b1);
        txn(1'b0, 32'h0000_2010, 32'h0, 4'hF, 32'hA5A5_0002, 0, 1'b0);
        idle(2);
        txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'hCAFE_F00D, TO + 2, 1'b0);
        idle(3);
        txn(1'b0, 32'h0000_4004, 32'h0, 4'hF, 32'h0BAD_CAFE, TO - 1, 1'b0);
        idle(1);
        repeat (40) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
                $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        @(negedge clk);
        mon_en = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = $urandom; bus.mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        hold_rdata = '0; hold_cnt = '0; model_cnt = '0; prev_req = 1'b0; run = 0;
        mon_en = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        idle(1);
        txn(1'b0, 32'h0000_5008, 32'h0, 4'hF, 32'h1357_9BDF, 1, 1'b0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
